// File: rtl/tick_counter.sv
// Prescaled up/down counter with wrap or saturate at a programmable limit.
// Prescaling is a clock enable on clk; tc flags a step taken at the limit.
module tick_counter #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PS_W-1:0]  ps_div,
    input  logic             up,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    logic [PS_W-1:0]  r_ps_cnt;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_ps_hit;
    logic             w_tick;
    logic             w_limit;
    logic [WIDTH-1:0] w_next_count;

    // Limit is judged on the pre-step count against the live max_val/up.
    function automatic logic f_at_limit(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] mx,
        input logic             dir_up
    );
        if (dir_up) begin
            return (cnt >= mx);
        end
        return (cnt == '0);
    endfunction

    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] mx,
        input logic             dir_up,
        input logic             sat
    );
        logic [WIDTH-1:0] nxt;
        nxt = cnt;
        if (dir_up) begin
            if (cnt < mx) begin
                nxt = cnt + WIDTH'(1);
            end else if (!sat) begin
                nxt = '0;
            end
        end else begin
            if (cnt != '0) begin
                nxt = cnt - WIDTH'(1);
            end else if (!sat) begin
                nxt = mx;
            end
        end
        return nxt;
    endfunction

    // >= rather than == so that lowering ps_div mid-count ticks on the next enabled cycle.
    assign w_ps_hit     = (r_ps_cnt >= ps_div);
    assign w_tick       = en & w_ps_hit & ~load & ~rst;
    assign w_limit      = f_at_limit(r_count, max_val, up);
    assign w_next_count = f_step(r_count, max_val, up, sat_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_ps_cnt <= '0;
            r_tc     <= 1'b0;
        end else if (load) begin
            r_count  <= load_val;
            r_ps_cnt <= '0;
            r_tc     <= 1'b0;
        end else if (w_tick) begin
            r_count  <= w_next_count;
            r_ps_cnt <= '0;
            r_tc     <= w_limit;
        end else begin
            r_tc <= 1'b0;
            if (en) begin
                r_ps_cnt <= r_ps_cnt + PS_W'(1);
            end
        end
    end

    assign count = r_count;
    assign tick  = w_tick;
    assign tc    = r_tc;

endmodule

// File: tb/tb_tick_counter.sv
// Randomized and directed bench for tick_counter against a behavioural model.
module tb_tick_counter;

    localparam int WIDTH = 8;
    localparam int PS_W  = 25;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [PS_W-1:0]  ps_div;
    logic             up;
    logic             sat_mode;
    logic [WIDTH-1:0] max_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: plain integers following the counting rules directly.
    int m_cnt = 0;
    int m_ps  = 0;
    int m_tc  = 0;

    tick_counter #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ps_div   (ps_div),
        .up       (up),
        .sat_mode (sat_mode),
        .max_val  (max_val),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic cyc();
        int exp_tick;
        int mx;
        mx = int'(max_val);
        exp_tick = (en && (m_ps >= int'(ps_div)) && !load && !rst) ? 1 : 0;
        #1;
        chk("tick",  32'(tick),  32'(exp_tick));
        chk("count", 32'(count), 32'(m_cnt));
        chk("tc",    32'(tc),    32'(m_tc));
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_ps = 0; m_tc = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_ps = 0; m_tc = 0;
        end else if (exp_tick == 1) begin
            m_ps = 0;
            if (up) begin
                m_tc  = (m_cnt >= mx) ? 1 : 0;
                m_cnt = (m_cnt < mx) ? m_cnt + 1 : (sat_mode ? m_cnt : 0);
            end else begin
                m_tc  = (m_cnt == 0) ? 1 : 0;
                m_cnt = (m_cnt > 0) ? m_cnt - 1 : (sat_mode ? m_cnt : mx);
            end
        end else begin
            m_tc = 0;
            if (en) m_ps = m_ps + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ps_div = '0; up = 1'b1; sat_mode = 1'b0;
        max_val = 8'd5; load = 1'b0; load_val = '0;
        @(negedge clk);
        cyc();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_tc",    32'(tc),    32'd0);

        // Wrap up-count, divide by 4, limit 5
        ps_div = 3; up = 1'b1; sat_mode = 1'b0; max_val = 8'd5;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("wrap_first_step", 32'(count), 32'd1);
        for (int i = 0; i < 20; i++) cyc();
        chk("wrap_to_zero", 32'(count), 32'd0);
        chk("wrap_tc",      32'(tc),    32'd1);
        cyc();
        chk("wrap_tc_once", 32'(tc), 32'd0);

        // Saturating up-count holds at 5 and re-pulses tc
        sat_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_reach", 32'(count), 32'd5);
        chk("sat_reach_tc", 32'(tc), 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        chk("sat_hold", 32'(count), 32'd5);
        chk("sat_tc",   32'(tc),    32'd1);
        for (int i = 0; i < 4; i++) cyc();
        chk("sat_tc_again", 32'(tc), 32'd1);

        // Down-count wraps from 0 to max_val every cycle
        up = 1'b0; sat_mode = 1'b0; max_val = 8'd9; ps_div = 0;
        do_reset();
        cyc();
        chk("down_wrap",    32'(count), 32'd9);
        chk("down_wrap_tc", 32'(tc),    32'd1);
        cyc();
        chk("down_step", 32'(count), 32'd8);

        // Load beats a coincident tick, value unclamped
        up = 1'b1; max_val = 8'd10; load = 1'b1; load_val = 8'd200;
        cyc();
        load = 1'b0;
        chk("load_val", 32'(count), 32'd200);
        chk("load_tc",  32'(tc),    32'd0);
        cyc();
        chk("over_limit_wrap", 32'(count), 32'd0);
        chk("over_limit_tc",   32'(tc),    32'd1);

        // Prescaler holds while disabled
        ps_div = 2; max_val = 8'd5;
        do_reset();
        en = 1'b1; cyc();
        en = 1'b0; cyc(); cyc();
        en = 1'b1; cyc();
        chk("en_hold", 32'(count), 32'd0);
        cyc();
        chk("en_tick", 32'(count), 32'd1);

        // Reset overrides load and discards prescale progress
        ps_div = 5; max_val = 8'd20; load = 1'b1; load_val = 8'd7;
        cyc();
        load = 1'b0; cyc(); cyc();
        chk("pre_rst_count", 32'(count), 32'd7);
        rst = 1'b1; load = 1'b1; load_val = 8'd99;
        cyc();
        rst = 1'b0; load = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tc",    32'(tc),    32'd0);
        ps_div = 2;
        cyc(); cyc();
        chk("rst_no_early_tick", 32'(count), 32'd0);
        cyc();
        chk("rst_first_tick", 32'(count), 32'd1);

        // Randomized traffic including max_val of 0 and all-ones
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst  = ($urandom_range(0, 99) < 2);
            load = ($urandom_range(0, 99) < 4);
            en   = ($urandom_range(0, 99) < 80);
            load_val = WIDTH'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) ps_div = PS_W'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) up = ~up;
            if ($urandom_range(0, 29) == 0) sat_mode = ~sat_mode;
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0)      max_val = 8'd0;
                else if (r == 1) max_val = 8'd255;
                else if (r < 6)  max_val = WIDTH'($urandom_range(1, 6));
                else             max_val = WIDTH'($urandom_range(0, 255));
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_counter.md
TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (1..32).
REQ-002 Parameter PS_W, default 25, prescaler width in bits (1..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  prescaler/count enable.
REQ-006 ps_div  input  PS_W  prescale divisor; one step per ps_div+1 enabled clk cycles.
REQ-007 up  input  1  direction: 1 = count up, 0 = count down.
REQ-008 sat_mode  input  1  1 = saturate at limit, 0 = wrap.
REQ-009 max_val  input  WIDTH  upper count limit (inclusive).
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value loaded into count.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 tick  output  1  combinational step-qualifier pulse.
REQ-014 tc  output  1  registered terminal-count pulse.

Function
REQ-015 Block SHALL use no derived or gated clocks; prescaling SHALL be a clock-enable on clk only.
REQ-016 Internal prescaler ps_cnt (PS_W bits) SHALL hold when en=0.
REQ-017 tick SHALL equal en AND (ps_cnt >= ps_div) AND NOT load AND NOT rst.
REQ-018 On tick=1, ps_cnt SHALL return to 0; on en=1 and tick=0 and load=0, ps_cnt SHALL increment by 1.
REQ-019 ps_div=0 SHALL give tick on every enabled cycle; lowering ps_div below ps_cnt SHALL cause tick on the next enabled cycle.
REQ-020 count SHALL change only on a cycle with tick=1, load=1 or rst=1.
REQ-021 Up step: count < max_val -> count+1; count >= max_val -> 0 if sat_mode=0, unchanged if sat_mode=1.
REQ-022 Down step: count > 0 -> count-1; count == 0 -> max_val if sat_mode=0, unchanged if sat_mode=1.
REQ-023 Limit condition SHALL be count >= max_val (up) or count == 0 (down), evaluated on pre-step values.
REQ-024 tc SHALL be 1 for exactly the one cycle following a tick taken while the limit condition held, in either mode; otherwise 0.
REQ-025 In saturate mode, each further tick at the limit SHALL re-pulse tc.
REQ-026 load=1 SHALL set count to load_val unclamped, ps_cnt to 0 and tc to 0, regardless of en; load SHALL take priority over a step.
REQ-027 Changes on up, sat_mode or max_val SHALL take effect on the next tick with no pipeline delay.
REQ-028 max_val=0 SHALL hold count at 0 in both directions, with tc pulsing on every tick.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH with no carry-out port; WIDTH-bit all-ones max_val SHALL wrap to 0 without overflow error.

Reset
REQ-030 rst=1 SHALL set count=0, ps_cnt=0, tc=0 at the next clk edge, overriding load and en.
REQ-031 rst asserted mid-prescale or mid-count SHALL discard all partial progress; first tick after release SHALL occur ps_div+1 enabled cycles later.

Verification
REQ-032 WIDTH=8, ps_div=3, up=1, sat_mode=0, max_val=5, en=1 from reset -> count steps every 4 clks, 0,1,...,5,0; tc high the cycle after 5->0.
REQ-033 Same setup, sat_mode=1 -> count stops at 5, then tc pulses once per 4 clks while count holds at 5.
REQ-034 up=0, max_val=9, sat_mode=0, ps_div=0, count=0 -> next edge count=9 and tc=1, then 8,7,... every cycle.
REQ-035 load=1 with load_val=200, max_val=10, up=1, coinciding with tick -> count=200 and no step; next tick gives count=0 and tc=1.
REQ-036 en toggled 1,0,0,1 with ps_div=2 -> ps_cnt holds during en=0; tick after 3 enabled cycles total; count unchanged while en=0.
REQ-037 rst=1 for one cycle while count=7, ps_cnt=2 and load=1 -> count=0, tc=0, ps_cnt=0; load ignored.
